// File: rtl/reg_cmd_sequencer.sv
// Command sequencer for a four-register bank: accepts one register command and
// drives the bank's enable, function select and load data for one or more cycles.
module reg_cmd_sequencer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  CmdValid,
    output logic                  CmdReady,
    input  logic [1:0]            CmdReg,
    input  logic [1:0]            CmdOp,
    input  logic [3:0]            CmdCount,
    input  logic [DATA_WIDTH-1:0] CmdData,
    output logic [3:0]            E,
    output logic [1:0]            FunSel,
    output logic [DATA_WIDTH-1:0] I,
    output logic                  Busy,
    output logic                  Done
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            tgt_q, tgt_d;
    logic [1:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [3:0]            remain_q, remain_d;
    logic                  done_q, done_d;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            tgt_q    <= 2'd0;
            op_q     <= 2'd0;
            data_q   <= '0;
            remain_q <= 4'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            op_q     <= op_d;
            data_q   <= data_d;
            remain_q <= remain_d;
            done_q   <= done_d;
        end
    end

    // Load and clear (op[1]=1) issue once, so their repeat count is forced to zero.
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        op_d     = op_q;
        data_d   = data_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (CmdValid) begin
                    state_d  = ISSUE;
                    tgt_d    = CmdReg;
                    op_d     = CmdOp;
                    data_d   = CmdData;
                    remain_d = CmdOp[1] ? 4'd0 : CmdCount;
                end
            end
            ISSUE: begin
                if (remain_q == 4'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    remain_d = remain_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        CmdReady = (state_q == IDLE);
        Busy     = (state_q == ISSUE);
        Done     = done_q;
        E        = 4'b0000;
        FunSel   = 2'b00;
        I        = '0;
        if (state_q == ISSUE) begin
            E      = 4'b0001 << tgt_q;
            FunSel = op_q;
            I      = data_q;
        end
    end

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Self-checking bench for reg_cmd_sequencer: a cycle model of the command
// protocol is compared every cycle, plus directed checks with literal values.
module tb_reg_cmd_sequencer;

    localparam int W = 16;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         CmdValid;
    logic         CmdReady;
    logic [1:0]   CmdReg;
    logic [1:0]   CmdOp;
    logic [3:0]   CmdCount;
    logic [W-1:0] CmdData;
    logic [3:0]   E;
    logic [1:0]   FunSel;
    logic [W-1:0] I;
    logic         Busy;
    logic         Done;

    int checks = 0;
    int fails  = 0;

    reg_cmd_sequencer #(.DATA_WIDTH(W)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .CmdValid (CmdValid),
        .CmdReady (CmdReady),
        .CmdReg   (CmdReg),
        .CmdOp    (CmdOp),
        .CmdCount (CmdCount),
        .CmdData  (CmdData),
        .E        (E),
        .FunSel   (FunSel),
        .I        (I),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a command occupies the bank for a number of issue cycles
    // (count+1 for inc/dec, 1 otherwise); Done follows the last issue cycle.
    int           mLeft = 0;
    logic [1:0]   mReg  = 2'd0;
    logic [1:0]   mOp   = 2'd0;
    logic [W-1:0] mData = '0;
    bit           mDone = 1'b0;
    bit           modelOn = 1'b0;

    always @(posedge Clock) begin
        if (Reset) begin
            mLeft   = 0;
            mDone   = 1'b0;
            mReg    = 2'd0;
            mOp     = 2'd0;
            mData   = '0;
            modelOn = 1'b1;
        end else if (mLeft > 0) begin
            mLeft = mLeft - 1;
            mDone = (mLeft == 0);
        end else begin
            mDone = 1'b0;
            if (CmdValid) begin
                mReg  = CmdReg;
                mOp   = CmdOp;
                mData = CmdData;
                mLeft = (CmdOp == 2'b00 || CmdOp == 2'b01) ? int'(CmdCount) + 1 : 1;
            end
        end
    end

    always @(negedge Clock) begin
        logic [3:0] expE;
        if (modelOn) begin
            expE = (mLeft > 0) ? 4'(1 << mReg) : 4'b0000;
            checkOutput("model.CmdReady", 32'(CmdReady), 32'(mLeft == 0));
            checkOutput("model.Busy", 32'(Busy), 32'(mLeft > 0));
            checkOutput("model.E", 32'(E), 32'(expE));
            checkOutput("model.FunSel", 32'(FunSel), 32'((mLeft > 0) ? mOp : 2'b00));
            checkOutput("model.I", 32'(I), 32'((mLeft > 0) ? mData : '0));
            checkOutput("model.Done", 32'(Done), 32'(mDone));
        end
    end

    // Small register bank driven by the DUT, to observe the net effect of commands.
    logic [W-1:0] bank [4];
    always @(posedge Clock) begin
        for (int n = 0; n < 4; n++) begin
            if (!Reset && E[n]) begin
                case (FunSel)
                    2'b00: bank[n] <= bank[n] - 1'b1;
                    2'b01: bank[n] <= bank[n] + 1'b1;
                    2'b10: bank[n] <= I;
                    default: bank[n] <= '0;
                endcase
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] op,
                                 input logic [3:0] cnt, input logic [W-1:0] data);
        @(posedge Clock);
        #1;
        CmdValid = 1'b1;
        CmdReg   = r;
        CmdOp    = op;
        CmdCount = cnt;
        CmdData  = data;
        @(posedge Clock);
        #1;
        CmdValid = 1'b0;
        CmdReg   = 2'($urandom);
        CmdOp    = 2'($urandom);
        CmdCount = 4'($urandom);
        CmdData  = W'($urandom);
    endtask

    // Counts enable cycles until Done; also records the first issue cycle's outputs.
    task automatic waitBurst(output int eCnt, output logic [3:0] firstE,
                             output logic [1:0] firstF, output logic [W-1:0] firstI);
        bit gotDone;
        eCnt    = 0;
        gotDone = 1'b0;
        firstE  = 4'b0000;
        firstF  = 2'b00;
        firstI  = '0;
        for (int k = 0; k < 40 && !gotDone; k++) begin
            @(negedge Clock);
            if (k == 0) begin
                firstE = E;
                firstF = FunSel;
                firstI = I;
            end
            if (E != 4'b0000) eCnt++;
            if (Done) gotDone = 1'b1;
        end
        checkOutput("burst.doneSeen", 32'(gotDone), 32'd1);
    endtask

    initial begin
        int           eCnt;
        int           readyLow;
        int           doneCnt;
        logic [3:0]   fE;
        logic [1:0]   fF;
        logic [W-1:0] fI;

        for (int n = 0; n < 4; n++) bank[n] = '0;
        Reset    = 1'b1;
        CmdValid = 1'b0;
        CmdReg   = 2'd0;
        CmdOp    = 2'd0;
        CmdCount = 4'd0;
        CmdData  = '0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        checkOutput("reset.CmdReady", 32'(CmdReady), 32'd1);
        checkOutput("reset.E", 32'(E), 32'd0);

        $display("[TB] load register 2");
        applyStimulus(2'd2, 2'b10, 4'd9, 16'hBEEF);
        waitBurst(eCnt, fE, fF, fI);
        checkOutput("load.E", 32'(fE), 32'h4);
        checkOutput("load.FunSel", 32'(fF), 32'h2);
        checkOutput("load.I", 32'(fI), 32'hBEEF);
        checkOutput("load.cycles", 32'(eCnt), 32'd1);
        checkOutput("load.bank2", 32'(bank[2]), 32'hBEEF);

        $display("[TB] increment register 0 from 5");
        applyStimulus(2'd0, 2'b10, 4'd0, 16'd5);
        waitBurst(eCnt, fE, fF, fI);
        applyStimulus(2'd0, 2'b01, 4'd3, 16'h1111);
        waitBurst(eCnt, fE, fF, fI);
        checkOutput("inc.E", 32'(fE), 32'h1);
        checkOutput("inc.FunSel", 32'(fF), 32'h1);
        checkOutput("inc.cycles", 32'(eCnt), 32'd4);
        checkOutput("inc.bank0", 32'(bank[0]), 32'd9);

        $display("[TB] clear register 3 with count ignored");
        applyStimulus(2'd3, 2'b11, 4'd9, 16'h5A5A);
        waitBurst(eCnt, fE, fF, fI);
        checkOutput("clear.E", 32'(fE), 32'h8);
        checkOutput("clear.cycles", 32'(eCnt), 32'd1);

        $display("[TB] busy blocking with a held second command");
        @(posedge Clock);
        #1;
        CmdValid = 1'b1;
        CmdReg   = 2'd1;
        CmdOp    = 2'b00;
        CmdCount = 4'd5;
        CmdData  = 16'h0F0F;
        @(posedge Clock);
        #1;
        CmdReg   = 2'd2;
        CmdOp    = 2'b10;
        CmdCount = 4'd7;
        CmdData  = 16'h1234;
        readyLow = 0;
        eCnt     = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clock);
            if (!CmdReady) readyLow++;
            if (E == 4'b0010 && FunSel == 2'b00) eCnt++;
            if (Done) break;
        end
        checkOutput("busy.doneReached", 32'(Done), 32'd1);
        @(posedge Clock);
        #1;
        CmdValid = 1'b0;
        checkOutput("busy.readyLow", 32'(readyLow), 32'd6);
        checkOutput("busy.firstCycles", 32'(eCnt), 32'd6);
        waitBurst(eCnt, fE, fF, fI);
        checkOutput("busy.secondE", 32'(fE), 32'h4);
        checkOutput("busy.secondI", 32'(fI), 32'h1234);
        checkOutput("busy.secondCycles", 32'(eCnt), 32'd1);

        $display("[TB] reset during an increment");
        applyStimulus(2'd1, 2'b01, 4'd7, 16'h0);
        @(posedge Clock);
        #1;
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        checkOutput("abort.E", 32'(E), 32'd0);
        checkOutput("abort.Busy", 32'(Busy), 32'd0);
        checkOutput("abort.CmdReady", 32'(CmdReady), 32'd1);
        doneCnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clock);
            if (Done) doneCnt++;
        end
        checkOutput("abort.noDone", 32'(doneCnt), 32'd0);

        $display("[TB] command during reset edge");
        @(posedge Clock);
        #1;
        Reset    = 1'b1;
        CmdValid = 1'b1;
        CmdOp    = 2'b01;
        CmdCount = 4'd2;
        @(posedge Clock);
        #1;
        Reset    = 1'b0;
        CmdValid = 1'b0;
        @(negedge Clock);
        checkOutput("resetCmd.Busy", 32'(Busy), 32'd0);

        $display("[TB] boundary counts");
        applyStimulus(2'd3, 2'b00, 4'd15, 16'h0);
        waitBurst(eCnt, fE, fF, fI);
        checkOutput("count15.cycles", 32'(eCnt), 32'd16);
        applyStimulus(2'd3, 2'b00, 4'd0, 16'h0);
        waitBurst(eCnt, fE, fF, fI);
        checkOutput("count0dec.cycles", 32'(eCnt), 32'd1);
        applyStimulus(2'd1, 2'b01, 4'd0, 16'h0);
        waitBurst(eCnt, fE, fF, fI);
        checkOutput("count0inc.cycles", 32'(eCnt), 32'd1);

        repeat (3) @(posedge Clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
